// File: rtl/disp_pkg.sv
// Shared definitions for the two-digit multiplexed display scanner.
package disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW0,
        ST_BLANK0,
        ST_SHOW1,
        ST_BLANK1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_D0   = 2'b01;
    localparam logic [1:0] SEL_D1   = 2'b10;

    localparam int unsigned DIV_DEFAULT   = 50000;
    localparam int unsigned BLANK_DEFAULT = 16;

endpackage

// File: rtl/seg7_dec.sv
// Hex to active-low seven-segment decoder, output ordered {g,f,e,d,c,b,a}.
module seg7_dec (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        unique case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
        endcase
    end

endmodule

// File: rtl/disp_scan.sv
// Two-digit display scanner: show/blank dwell FSM with per-frame input snapshots
// and registered outputs derived from the next state (zero-latency on state entry).
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned DIV   = DIV_DEFAULT,
    parameter int unsigned BLANK = BLANK_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [3:0] D_IN0,
    input  logic [3:0] D_IN1,
    output logic [1:0] SEL,
    output logic [6:0] SEG,
    output logic       FRAME
);

    // Counter sized for DIV, widened only if BLANK would not otherwise fit.
    localparam int unsigned CW_DIV = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
    localparam int unsigned CW_BLK = ($clog2(BLANK) < 1) ? 1 : $clog2(BLANK);
    localparam int unsigned CW     = (CW_DIV > CW_BLK) ? CW_DIV : CW_BLK;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    snap0_q, snap0_d;
    logic [3:0]    snap1_q, snap1_d;
    logic [1:0]    sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_q, frame_d;
    logic          enter_show0;
    logic [3:0]    dec_in;
    logic [6:0]    dec_out;

    seg7_dec u_dec (
        .hex_i (dec_in),
        .seg_o (dec_out)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (EN) state_d = ST_SHOW0;
            ST_SHOW0:  if (!EN) state_d = ST_IDLE;
                       else if (cnt_q == DIV_LAST) state_d = ST_BLANK0;
            ST_BLANK0: if (!EN) state_d = ST_IDLE;
                       else if (cnt_q == BLANK_LAST) state_d = ST_SHOW1;
            ST_SHOW1:  if (!EN) state_d = ST_IDLE;
                       else if (cnt_q == DIV_LAST) state_d = ST_BLANK1;
            ST_BLANK1: if (!EN) state_d = ST_IDLE;
                       else if (cnt_q == BLANK_LAST) state_d = ST_SHOW0;
            default:   state_d = ST_IDLE;
        endcase

        cnt_d = ((state_d != state_q) || (state_d == ST_IDLE)) ? '0 : cnt_q + 1'b1;

        enter_show0 = (state_d == ST_SHOW0) && (state_q != ST_SHOW0);
        snap0_d     = enter_show0 ? D_IN0 : snap0_q;
        snap1_d     = enter_show0 ? D_IN1 : snap1_q;

        // Decode the snapshot that will be visible after this edge.
        dec_in  = (state_d == ST_SHOW1) ? snap1_d : snap0_d;
        sel_d   = SEL_NONE;
        seg_d   = SEG_BLANK;
        frame_d = enter_show0;
        unique case (state_d)
            ST_SHOW0: begin
                sel_d = SEL_D0;
                seg_d = dec_out;
            end
            ST_SHOW1: begin
                sel_d = SEL_D1;
                seg_d = dec_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap0_q <= '0;
            snap1_q <= '0;
            sel_q   <= SEL_NONE;
            seg_q   <= SEG_BLANK;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap0_q <= snap0_d;
            snap1_q <= snap1_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign SEL   = sel_q;
    assign SEG   = seg_q;
    assign FRAME = frame_q;

endmodule
